// File: rtl/ara_pkg.sv
// Shared types and helpers for the VLSU store-side W alignment stage.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package ara_pkg;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_STREAM = 2'd1,
      W_DRAIN  = 2'd2
   } w_align_state_e;

   // Number of beats needed to carry nbytes when a beat holds 2**log2b bytes.
   function automatic logic [31:0] beat_count(input logic [31:0] nbytes, input int unsigned log2b);
      logic [31:0] bpb;
      bpb = 32'd1 << log2b;
      return (nbytes + bpb - 32'd1) >> log2b;
   endfunction

endpackage

// File: rtl/byte_rotate.sv
// Rotates a beat left by a runtime byte amount: byte j lands at (j+amt) mod B.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module byte_rotate #(
   parameter int unsigned AxiDataWidth = 128,
   localparam int unsigned B = AxiDataWidth / 8,
   localparam int unsigned AmtW = $clog2(B)
) (
   input  logic [AxiDataWidth-1:0] data_i,
   input  logic [AmtW-1:0]         amt_i,
   output logic [AxiDataWidth-1:0] data_o
);

   logic [AmtW-1:0] dst;

   // Destination index wraps naturally because it is exactly log2(B) bits wide.
   always_comb begin
      data_o = '0;
      dst    = '0;
      for (int j = 0; j < B; j++) begin
         dst = AmtW'(j) + amt_i;
         data_o[8*dst +: 8] = data_i[8*j +: 8];
      end
   end

endmodule

// File: rtl/fifo_v3.sv
// Small generic synchronous FIFO (registered read data, no fall-through).
// Latency: one cycle from push to visibility at data_o.
// Backpressure: pushes ignored when full, pops ignored when empty.
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8,
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic                  full_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i,
   output logic                  empty_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]       wptr_q, rptr_q;
   logic [CntW-1:0]       cnt_q;
   logic                  push_ok, pop_ok;

   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rptr_q];

   // Storage, wrapping pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
            wptr_q <= (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rptr_q <= (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
         end
         if (push_ok && !pop_ok)      cnt_q <= cnt_q + CntW'(1);
         else if (pop_ok && !push_ok) cnt_q <= cnt_q - CntW'(1);
      end
   end

endmodule

// File: rtl/w_align_stage.sv
// Rotates byte-packed VLSU store data to the memory byte offset, builds W strobes and per-burst w_last.
// Latency: zero added cycles in STREAM (output is combinational from input and held beat); one trailing DRAIN beat when needed.
// Backpressure: in_ready follows w_ready; no W beat is offered while the AW burst-length FIFO is empty.
module w_align_stage
   import ara_pkg::*;
#(
   parameter int unsigned AxiDataWidth = 128,
   parameter int unsigned MaxBytes     = 4096,
   parameter int unsigned NumBursts    = 8,
   localparam int unsigned B    = AxiDataWidth / 8,
   localparam int unsigned OffW = $clog2(B),
   localparam int unsigned NbW  = $clog2(MaxBytes + 1)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [OffW-1:0]         cmd_offset_i,
   input  logic [NbW-1:0]          cmd_nbytes_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [7:0]              aw_len_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [AxiDataWidth-1:0] in_data_i,
   output logic                    w_valid_o,
   input  logic                    w_ready_i,
   output logic [AxiDataWidth-1:0] w_data_o,
   output logic [B-1:0]            w_strb_o,
   output logic                    w_last_o
);

   // Wide enough for offset+nbytes, so beat counts never truncate.
   localparam int unsigned AccW = $clog2(MaxBytes + B + 1);

   w_align_state_e          state_q, state_d;
   logic [OffW-1:0]         off_q, off_d, end_q, end_d;
   logic [AccW-1:0]         in_left_q, in_left_d;
   logic                    extra_q, extra_d, first_q, first_d;
   logic [AxiDataWidth-1:0] held_q, held_d;
   logic [7:0]              wcnt_q, wcnt_d;

   logic [AccW-1:0]         total, in_beats, out_beats;
   logic                    cmd_go, in_hs, w_hs, last_in, is_last;
   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [7:0]              fifo_head;
   logic [AxiDataWidth-1:0] rot_in, rot_held, low_bits;
   logic [B-1:0]            low_mask, end_mask, strb;

   assign total     = AccW'(cmd_offset_i) + AccW'(cmd_nbytes_i);
   assign in_beats  = AccW'(beat_count(32'(cmd_nbytes_i), OffW));
   assign out_beats = AccW'(beat_count(32'(total), OffW));
   // A zero-byte command is accepted but never leaves IDLE.
   assign cmd_go    = cmd_ready_o && cmd_valid_i && (cmd_nbytes_i != '0);
   assign in_hs     = in_valid_i && in_ready_o;
   assign w_hs      = w_valid_o && w_ready_i;
   assign last_in   = (in_left_q == AccW'(1));

   assign aw_ready_o = !fifo_full;
   assign fifo_push  = aw_valid_i && !fifo_full;
   assign w_last_o   = w_valid_o && (wcnt_q == fifo_head);
   assign fifo_pop   = w_hs && w_last_o;

   byte_rotate #(.AxiDataWidth(AxiDataWidth)) u_rot_in (
      .data_i (in_data_i),
      .amt_i  (off_q),
      .data_o (rot_in)
   );

   byte_rotate #(.AxiDataWidth(AxiDataWidth)) u_rot_held (
      .data_i (held_q),
      .amt_i  (off_q),
      .data_o (rot_held)
   );

   fifo_v3 #(.DATA_WIDTH(8), .DEPTH(NumBursts)) u_burst_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .data_i  (aw_len_i),
      .push_i  (fifo_push),
      .full_o  (fifo_full),
      .data_o  (fifo_head),
      .pop_i   (fifo_pop),
      .empty_o (fifo_empty)
   );

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= W_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: leave STREAM after the last input beat, via DRAIN when one more output beat is owed.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         W_IDLE:   if (cmd_go) state_d = W_STREAM;
         W_STREAM: if (in_hs && last_in) state_d = extra_q ? W_DRAIN : W_IDLE;
         W_DRAIN:  if (w_hs) state_d = W_IDLE;
         default:  state_d = W_IDLE;
      endcase
   end

   // FSM handshake outputs; W traffic is gated on a known burst length being available.
   always_comb begin
      cmd_ready_o = 1'b0;
      in_ready_o  = 1'b0;
      w_valid_o   = 1'b0;
      unique case (state_q)
         W_IDLE:   cmd_ready_o = 1'b1;
         W_STREAM: begin
            w_valid_o  = in_valid_i && !fifo_empty;
            in_ready_o = w_ready_i && !fifo_empty;
         end
         W_DRAIN:  w_valid_o = !fifo_empty;
         default:  ;
      endcase
   end

   // Byte merge and strobes: bytes below the offset come from the previous (held) beat.
   always_comb begin
      low_mask = '0;
      end_mask = '0;
      low_bits = '0;
      for (int j = 0; j < B; j++) begin
         low_mask[j] = (OffW'(j) < off_q);
         end_mask[j] = (end_q == '0) || (OffW'(j) < end_q);
         low_bits[8*j +: 8] = {8{low_mask[j]}};
      end
      is_last = (state_q == W_DRAIN) || (!extra_q && last_in);
      strb = '1;
      if (first_q) strb = strb & ~low_mask;
      if (is_last) strb = strb & end_mask;
      w_strb_o = '0;
      w_data_o = '0;
      unique case (state_q)
         W_STREAM: begin
            w_strb_o = strb;
            w_data_o = (rot_in & ~low_bits) | (rot_held & low_bits);
         end
         W_DRAIN: begin
            w_strb_o = strb;
            w_data_o = rot_held & low_bits;
         end
         default: ;
      endcase
   end

   // Command latch on accept; held beat and remaining-beat count advance on each consumed input beat.
   always_comb begin
      off_d     = off_q;
      end_d     = end_q;
      in_left_d = in_left_q;
      extra_d   = extra_q;
      first_d   = first_q;
      held_d    = held_q;
      if (cmd_go) begin
         off_d     = cmd_offset_i;
         end_d     = total[OffW-1:0];
         in_left_d = in_beats;
         extra_d   = (out_beats > in_beats);
         first_d   = 1'b1;
         held_d    = '0;
      end else if (in_hs) begin
         held_d    = in_data_i;
         in_left_d = in_left_q - AccW'(1);
         first_d   = 1'b0;
      end
   end

   // Beats issued within the current AXI burst; restarts when w_last is taken.
   always_comb begin
      wcnt_d = wcnt_q;
      if (w_hs) wcnt_d = w_last_o ? 8'd0 : wcnt_q + 8'd1;
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         off_q     <= '0;
         end_q     <= '0;
         in_left_q <= '0;
         extra_q   <= 1'b0;
         first_q   <= 1'b0;
         held_q    <= '0;
         wcnt_q    <= '0;
      end else begin
         off_q     <= off_d;
         end_q     <= end_d;
         in_left_q <= in_left_d;
         extra_q   <= extra_d;
         first_q   <= first_d;
         held_q    <= held_d;
         wcnt_q    <= wcnt_d;
      end
   end

endmodule

// File: tb/tb_w_align_stage.sv
// Directed plus randomized bench for w_align_stage against a memory-image reference model.
// Latency: checks zero-added-latency streaming when w_ready is held high.
// Backpressure: randomly toggles w_ready and checks output stability while stalled.
module tb_w_align_stage;

   localparam int B = 16;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         cmd_valid_i;
   logic         cmd_ready_o;
   logic [3:0]   cmd_offset_i;
   logic [12:0]  cmd_nbytes_i;
   logic         aw_valid_i;
   logic         aw_ready_o;
   logic [7:0]   aw_len_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [127:0] in_data_i;
   logic         w_valid_o;
   logic         w_ready_i;
   logic [127:0] w_data_o;
   logic [15:0]  w_strb_o;
   logic         w_last_o;

   always #5 clk_i = ~clk_i;

   w_align_stage dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_offset_i (cmd_offset_i),
      .cmd_nbytes_i (cmd_nbytes_i),
      .aw_valid_i   (aw_valid_i),
      .aw_ready_o   (aw_ready_o),
      .aw_len_i     (aw_len_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_data_i    (in_data_i),
      .w_valid_o    (w_valid_o),
      .w_ready_i    (w_ready_i),
      .w_data_o     (w_data_o),
      .w_strb_o     (w_strb_o),
      .w_last_o     (w_last_o)
   );

   int           checks = 0;
   int           errors = 0;
   int           aw_q[$];
   int           w_in_burst;
   logic [15:0]  exp_strb_q[$];
   logic [127:0] exp_data_q[$];
   logic [7:0]   payload [0:255];
   bit           prev_stall;
   logic [127:0] prev_data;
   logic [15:0]  prev_strb;
   int           n_in_hs;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the inputs settle, score, update the model, move to next negedge.
   task automatic step();
      bit           exp_awr, last_exp;
      logic [127:0] mask;
      #1;
      exp_awr = (aw_q.size() < 8);
      chk("aw_ready", aw_ready_o, exp_awr);
      if (prev_stall && w_valid_o) begin
         chk("stall_data", w_data_o, prev_data);
         chk("stall_strb", w_strb_o, prev_strb);
      end
      prev_stall = w_valid_o && !w_ready_i;
      prev_data  = w_data_o;
      prev_strb  = w_strb_o;
      if (w_valid_o && w_ready_i) begin
         if (exp_strb_q.size() == 0 || aw_q.size() == 0) begin
            chk("spurious_w", w_valid_o, 1'b0);
         end else begin
            mask = '0;
            for (int j = 0; j < B; j++) mask[8*j +: 8] = {8{exp_strb_q[0][j]}};
            last_exp = (w_in_burst == aw_q[0]);
            chk("w_strb", w_strb_o, exp_strb_q[0]);
            chk("w_data", w_data_o & mask, exp_data_q[0]);
            chk("w_last", w_last_o, last_exp);
            void'(exp_strb_q.pop_front());
            void'(exp_data_q.pop_front());
            if (last_exp) begin
               void'(aw_q.pop_front());
               w_in_burst = 0;
            end else begin
               w_in_burst++;
            end
         end
      end
      if (in_valid_i && in_ready_o) n_in_hs++;
      if (aw_valid_i && exp_awr) aw_q.push_back(int'(aw_len_i));
      @(negedge clk_i);
   endtask

   task automatic push_aw(input int len);
      aw_valid_i = 1'b1;
      aw_len_i   = 8'(len);
      step();
      aw_valid_i = 1'b0;
   endtask

   task automatic check_reset_vals();
      chk("rst_cmd_ready", cmd_ready_o, 1'b1);
      chk("rst_aw_ready", aw_ready_o, 1'b1);
      chk("rst_in_ready", in_ready_o, 1'b0);
      chk("rst_w_valid", w_valid_o, 1'b0);
      chk("rst_w_last", w_last_o, 1'b0);
      chk("rst_w_strb", w_strb_o, 16'h0);
      chk("rst_w_data", w_data_o, 128'h0);
   endtask

   // Expected beats come from placing the payload at [off, off+nb) in memory and cutting it into B-byte beats.
   task automatic run_cmd(input int off, input int nb, input bit seq, input bit rnd_rdy,
                          input bit aw_live, input int abort_at, output int cycles);
      int           in_beats, out_beats, pos, idx;
      logic [127:0] d;
      logic [15:0]  s;
      for (int i = 0; i < nb; i++) payload[i] = seq ? 8'(i) : 8'($urandom);
      in_beats  = (nb + B - 1) / B;
      out_beats = (nb == 0) ? 0 : (off + nb + B - 1) / B;
      for (int k = 0; k < out_beats; k++) begin
         s = '0;
         d = '0;
         for (int j = 0; j < B; j++) begin
            pos = k * B + j;
            if (pos >= off && pos < off + nb) begin
               s[j] = 1'b1;
               d[8*j +: 8] = payload[pos - off];
            end
         end
         exp_strb_q.push_back(s);
         exp_data_q.push_back(d);
      end
      prev_stall   = 1'b0;
      cmd_valid_i  = 1'b1;
      cmd_offset_i = 4'(off);
      cmd_nbytes_i = 13'(nb);
      #1;
      chk("cmd_ready", cmd_ready_o, 1'b1);
      step();
      cmd_valid_i = 1'b0;
      n_in_hs = 0;
      cycles  = 0;
      while (exp_strb_q.size() > 0 && cycles < 200 &&
             (abort_at < 0 || out_beats - exp_strb_q.size() < abort_at)) begin
         in_valid_i = (n_in_hs < in_beats);
         d = '0;
         for (int j = 0; j < B; j++) begin
            idx = n_in_hs * B + j;
            if (idx < nb) d[8*j +: 8] = payload[idx];
         end
         in_data_i  = d;
         w_ready_i  = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         aw_valid_i = aw_live;
         aw_len_i   = 8'd0;
         step();
         cycles++;
      end
      in_valid_i = 1'b0;
      aw_valid_i = 1'b0;
      w_ready_i  = 1'b0;
      if (abort_at < 0) begin
         chk("beats_left", exp_strb_q.size(), 0);
         chk("in_beats", n_in_hs, in_beats);
         #1;
         chk("idle_after", cmd_ready_o, 1'b1);
         step();
      end
   endtask

   initial begin
      int cyc, off, nb, rem, l;
      rst_ni       = 1'b0;
      cmd_valid_i  = 1'b0;
      cmd_offset_i = '0;
      cmd_nbytes_i = '0;
      aw_valid_i   = 1'b0;
      aw_len_i     = '0;
      in_valid_i   = 1'b0;
      in_data_i    = '0;
      w_ready_i    = 1'b0;
      w_in_burst   = 0;
      prev_stall   = 1'b0;
      @(negedge clk_i);
      #1;
      check_reset_vals();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // offset 4, 32 bytes, one burst of 3 beats; third beat is the drain beat.
      push_aw(2);
      run_cmd(4, 32, 1'b1, 1'b0, 1'b0, -1, cyc);
      chk("lat_off4", cyc, 3);
      // aligned 20 bytes: two back-to-back beats.
      push_aw(1);
      run_cmd(0, 20, 1'b1, 1'b0, 1'b0, -1, cyc);
      chk("lat_off0", cyc, 2);
      // single beat at the top of the word.
      push_aw(0);
      run_cmd(12, 4, 1'b1, 1'b0, 1'b0, -1, cyc);
      chk("lat_single", cyc, 1);
      // same 3-beat command split over two bursts.
      push_aw(0);
      push_aw(1);
      run_cmd(4, 32, 1'b1, 1'b0, 1'b0, -1, cyc);
      chk("lat_split", cyc, 3);
      // zero-byte command produces nothing and leaves the pending burst alone.
      push_aw(0);
      run_cmd(5, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
      w_ready_i = 1'b1;
      step();
      #1;
      chk("nb0_no_valid", w_valid_o, 1'b0);
      step();
      w_ready_i = 1'b0;
      run_cmd(0, 16, 1'b0, 1'b0, 1'b0, -1, cyc);

      // fill the burst FIFO, then overflow attempt, then push+pop in one cycle.
      for (int i = 0; i < 8; i++) push_aw(0);
      #1;
      chk("aw_full", aw_ready_o, 1'b0);
      push_aw(0);
      run_cmd(0, 16, 1'b0, 1'b0, 1'b0, -1, cyc);
      run_cmd(3, 10, 1'b0, 1'b0, 1'b1, -1, cyc);
      #1;
      chk("aw_after_pushpop", aw_ready_o, 1'b1);
      push_aw(0);
      #1;
      chk("aw_full_again", aw_ready_o, 1'b0);
      for (int i = 0; i < 8 && aw_q.size() > 0; i++) run_cmd(0, 16, 1'b0, 1'b1, 1'b0, -1, cyc);
      chk("fifo_drained", aw_q.size(), 0);

      // randomized commands with random burst splits and random W backpressure.
      for (int t = 0; t < 12; t++) begin
         off = $urandom_range(0, 15);
         nb  = $urandom_range(1, 100);
         rem = (off + nb + B - 1) / B;
         while (rem > 0) begin
            l = $urandom_range(1, rem);
            push_aw(l - 1);
            rem -= l;
         end
         run_cmd(off, nb, 1'b0, 1'b1, 1'b0, -1, cyc);
      end

      // reset in the middle of a burst, then a fresh command.
      push_aw(2);
      run_cmd(4, 32, 1'b1, 1'b0, 1'b0, 1, cyc);
      in_valid_i = 1'b1;
      w_ready_i  = 1'b1;
      rst_ni     = 1'b0;
      #1;
      check_reset_vals();
      aw_q.delete();
      exp_strb_q.delete();
      exp_data_q.delete();
      w_in_burst = 0;
      prev_stall = 1'b0;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      w_ready_i  = 1'b0;
      rst_ni     = 1'b1;
      @(negedge clk_i);
      push_aw(2);
      run_cmd(4, 32, 1'b1, 1'b0, 1'b0, -1, cyc);
      chk("lat_after_reset", cyc, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
